// File: rtl/hilo_div_unit.sv
// HI/LO register owner with a 32-iteration restoring divider for DIV/DIVU.
// Stalls EX-stage requests that need HI/LO while a divide is in flight.
module hilo_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    input  logic        mf_req,
    input  logic        mt_we,
    input  logic        hl_sel,
    input  logic [31:0] mt_data,
    output logic [31:0] mf_data,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state, state_nxt;
    logic [31:0] hi, lo;
    logic [31:0] dvd, dsr, rem, quo;
    logic [4:0]  cnt;
    logic        dvd_neg, dsr_neg, dsr_zero;

    logic        accept, mt_write;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub, rem_nxt;
    logic [31:0] dividend_abs, divisor_abs;
    logic [31:0] q_fix, r_fix;

    assign accept   = (state == IDLE) & start & ~flush;
    assign mt_write = (state == IDLE) & mt_we & ~start & ~flush;

    assign busy    = (state != IDLE);
    assign stall   = busy & (start | mf_req | mt_we);
    assign mf_data = hl_sel ? hi : lo;

    assign dividend_abs = (is_signed & dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign divisor_abs  = (is_signed & divisor[31])  ? (~divisor + 32'd1)  : divisor;

    // One restoring step; rem < dsr always holds, so the 32-bit difference is exact.
    assign rem_sh  = {rem, dvd[31]};
    assign rem_ge  = (rem_sh >= {1'b0, dsr});
    assign rem_sub = rem_sh[31:0] - dsr;
    assign rem_nxt = rem_ge ? rem_sub : rem_sh[31:0];

    // dvd_neg/dsr_neg are only set for DIV, so DIVU passes through unchanged.
    // With a zero divisor rem ends as |dividend|, so r_fix rebuilds the original.
    assign q_fix = (dvd_neg ^ dsr_neg) ? (~quo + 32'd1) : quo;
    assign r_fix = dvd_neg ? (~rem + 32'd1) : rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                if (flush)              state_nxt = IDLE;
                else if (cnt == 5'd31)  state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            dvd_neg  <= 1'b0;
            dsr_neg  <= 1'b0;
            dsr_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd      <= dividend_abs;
                        dsr      <= divisor_abs;
                        dvd_neg  <= is_signed & dividend[31];
                        dsr_neg  <= is_signed & divisor[31];
                        dsr_zero <= (divisor == 32'd0);
                        rem      <= '0;
                        quo      <= '0;
                        cnt      <= '0;
                    end else if (mt_write) begin
                        if (hl_sel) hi <= mt_data;
                        else        lo <= mt_data;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        rem <= rem_nxt;
                        dvd <= {dvd[30:0], 1'b0};
                        quo <= {quo[30:0], rem_ge};
                        cnt <= cnt + 5'd1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi   <= r_fix;
                        lo   <= dsr_zero ? 32'hFFFF_FFFF : q_fix;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: divide results, latency, stall, MT/MF, flush, reset.
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_signed, flush, mf_req, mt_we, hl_sel;
    logic [31:0] dividend, divisor, mt_data;
    logic [31:0] mf_data;
    logic        busy, stall, done;

    int checks = 0;
    int failures = 0;

    hilo_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .mf_req(mf_req), .mt_we(mt_we), .hl_sel(hl_sel), .mt_data(mt_data),
        .mf_data(mf_data), .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic sel, output logic [31:0] v);
        hl_sel = sel;
        #1;
        v = mf_data;
    endtask

    // Issue one divide, return the number of busy cycles observed.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        is_signed = s; dividend = a; divisor = b; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            tick();
        end
    endtask

    typedef struct {
        string       tag;
        logic        s;
        logic [31:0] a, b, lo, hi;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          cyc;
        logic [31:0] v;

        vecs[0] = '{"divu_100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
        vecs[1] = '{"div_m7_2",     1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF};
        vecs[2] = '{"div_min_m1",   1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
        vecs[3] = '{"divu_by0",     1'b0, 32'h1234,      32'd0,         32'hFFFFFFFF,  32'h1234};
        vecs[4] = '{"div_m7_by0",   1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF9};
        vecs[5] = '{"divu_big",     1'b0, 32'hFFFFFFFF,  32'h80000001,  32'd1,         32'h7FFFFFFE};

        rst_n = 1'b0; start = 0; is_signed = 0; flush = 0; mf_req = 0; mt_we = 0;
        hl_sel = 0; dividend = 0; divisor = 0; mt_data = 0;
        tick(); tick();
        mf_req = 1'b1;
        #1;
        chk("rst_busy",  busy,  0);
        chk("rst_done",  done,  0);
        chk("rst_stall", stall, 0);
        rd(1'b0, v); chk("rst_lo", v, 0);
        rd(1'b1, v); chk("rst_hi", v, 0);
        mf_req = 1'b0;
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            do_div(vecs[i].s, vecs[i].a, vecs[i].b, cyc);
            chk({vecs[i].tag, "_cycles"}, cyc, 33);
            chk({vecs[i].tag, "_done"}, done, 1);
            rd(1'b0, v); chk({vecs[i].tag, "_lo"}, v, vecs[i].lo);
            rd(1'b1, v); chk({vecs[i].tag, "_hi"}, v, vecs[i].hi);
            tick();
            chk({vecs[i].tag, "_done_off"}, done, 0);
        end

        // Signed mixed-sign case with positive dividend.
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, cyc);
        rd(1'b0, v); chk("div_7_m2_lo", v, 32'hFFFFFFFD);
        rd(1'b1, v); chk("div_7_m2_hi", v, 32'd1);
        tick();

        // MFHI raised in the second busy cycle: stalled for the remaining 32.
        is_signed = 0; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mf_req = 1'b1; hl_sel = 1'b1;
        #1;
        cyc = 0;
        while (stall && cyc < 100) begin
            cyc++;
            tick();
        end
        chk("mfhi_stall_cycles", cyc, 32);
        chk("mfhi_busy_low", busy, 0);
        chk("mfhi_data", mf_data, 32'd6);
        mf_req = 1'b0;
        tick();

        // Back-to-back divides: second start held until busy falls.
        is_signed = 0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        tick();
        dividend = 32'd50; divisor = 32'd3;
        #1;
        cyc = 0;
        while (stall && cyc < 100) begin
            cyc++;
            tick();
        end
        chk("b2b_stall_cycles", cyc, 33);
        chk("b2b_first_done", done, 1);
        rd(1'b0, v); chk("b2b_first_lo", v, 32'd14);
        tick();
        chk("b2b_second_accept", busy, 1);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            tick();
        end
        chk("b2b_second_cycles", cyc, 33);
        rd(1'b0, v); chk("b2b_second_lo", v, 32'd16);
        rd(1'b1, v); chk("b2b_second_hi", v, 32'd2);
        tick();

        // MTLO / MTHI.
        mt_we = 1'b1; hl_sel = 1'b0; mt_data = 32'hDEADBEEF;
        tick();
        mt_we = 1'b0;
        rd(1'b0, v); chk("mtlo_read", v, 32'hDEADBEEF);
        mt_we = 1'b1; hl_sel = 1'b1; mt_data = 32'h11111111;
        tick();
        mt_data = 32'h22222222; hl_sel = 1'b0;
        tick();
        mt_we = 1'b0;
        rd(1'b1, v); chk("mthi_read", v, 32'h11111111);
        rd(1'b0, v); chk("mtlo_read2", v, 32'h22222222);

        // Flush at RUN cycle 10.
        is_signed = 0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        tick();
        chk("flush_done_later", done, 0);
        rd(1'b1, v); chk("flush_hi_kept", v, 32'h11111111);
        rd(1'b0, v); chk("flush_lo_kept", v, 32'h22222222);

        // Start with flush in IDLE is not accepted.
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_idle_start", busy, 0);

        // Start and MTHI together: start wins, HI not written by MT.
        start = 1'b1; mt_we = 1'b1; hl_sel = 1'b1; mt_data = 32'h55;
        tick();
        start = 1'b0; mt_we = 1'b0;
        chk("start_mt_busy", busy, 1);
        rd(1'b1, v); chk("start_mt_hi", v, 32'h11111111);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            tick();
        end
        rd(1'b1, v); chk("start_mt_div_hi", v, 32'd2);
        tick();

        // Asynchronous reset during RUN.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        rd(1'b1, v); chk("arst_hi", v, 0);
        rd(1'b0, v); chk("arst_lo", v, 0);
        rst_n = 1'b1;
        tick();
        chk("arst_idle_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_div_unit.md
# hilo_div_unit

Multi-cycle divide sequencer and HI/LO register owner for the pipelined MIPS core. Accepts DIV/DIVU from the EX stage, runs a 32-iteration restoring division, and writes remainder to HI and quotient to LO. It serves MFHI/MFLO/MTHI/MTLO and drives a stall to the hazard unit whenever an instruction needs the unit while a divide is in flight.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  DIV/DIVU present in EX (decoder selected ALU_div).
- is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start.
- dividend  in  32  rs value; sampled with start.
- divisor  in  32  rt value; sampled with start.
- flush  in  1  pipeline kill; aborts any in-flight divide.
- mf_req  in  1  MFHI/MFLO in EX.
- mt_we  in  1  MTHI/MTLO in EX.
- hl_sel  in  1  0 = LO, 1 = HI (for mf_req and mt_we).
- mt_data  in  32  write data for MTHI/MTLO.
- mf_data  out  32  combinational read of selected HI/LO.
- busy  out  1  state != IDLE.
- stall  out  1  combinational: busy & (start | mf_req | mt_we).
- done  out  1  one-cycle pulse after HI/LO are written by a divide.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: start & !flush → latch |dividend|, |divisor| (absolute only when is_signed), sign bits, divisor-zero flag; clear remainder, count = 0; go RUN. mt_we & !flush (no start) → write mt_data to HI or LO per hl_sel. start and mt_we together: start wins; mt_we ignored.
- RUN: per cycle, rem = {rem[30:0], dvd[31]}; dvd <<= 1; if rem >= dsr (33-bit unsigned compare) then rem -= dsr, shift 1 into quotient, else shift 0. After 32 iterations (count 31 → wrap) go FIX.
- FIX: signed only: quotient negated if dividend and divisor signs differ; remainder takes dividend sign. Write HI = remainder, LO = quotient; go IDLE; done pulses next cycle.
- Divisor zero (either mode): HI = original dividend, LO = 0xFFFFFFFF, no sign fixup, same latency.
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (falls out of the algorithm; no trap).
- flush in RUN or FIX: return to IDLE next edge; HI/LO unchanged; no done. flush in IDLE with start: start not accepted.
- While busy: start, mf_req, mt_we are not acted on; stall holds them in EX until busy drops.
- Reset: state IDLE, HI = LO = 0, internal regs 0, busy = done = 0, stall = 0, mf_data = 0.

## Timing
- Edge E0 accepts start; busy high from E0 through E33 (33 cycles); HI/LO updated at E33; busy low and done high in cycle after E33.
- A stalled MFHI/MFLO sees new HI/LO in the first cycle busy is low (no bypass of FIX output).
- Back-to-back DIV: second start held by stall, accepted at the first edge with busy low; no idle bubble beyond that.
- MTHI/MTLO writes at the edge; following-cycle mf_data reflects it.
- Reset asserted mid-RUN: immediate return to IDLE, outputs to reset values; no partial HI/LO write.

## Test plan
- DIVU 100 / 7 → busy 33 cycles, then LO = 14, HI = 2, done one cycle.
- DIV 0xFFFFFFF9 (−7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 0x1234 / 0 → HI = 0x1234, LO = 0xFFFFFFFF after 33 cycles.
- MFHI asserted 1 cycle after start → stall high 32 cycles, then mf_data = new HI with stall low; second DIV held same way, accepted on busy fall.
- MTLO 0xDEADBEEF in IDLE → next cycle MFLO reads 0xDEADBEEF; flush at RUN cycle 10 → busy low next cycle, HI/LO unchanged, no done.
- rst_n low at RUN cycle 5 → state IDLE, HI = LO = 0, busy = 0 immediately (asynchronous).
